uart_responder: RTL and testbench
=================================

Name: uart_responder

Overview:
- Synthesizable model of the board UART chip, as seen from the CPU's UART port.
- Responds to the CPU's rdn/wrn strobes on the shared data bus and reports status on tbre, tsre and data_ready.
- Serializes written bytes onto txd and deserializes rxd into a receive buffer.
- Used as the device-side end of the UART interface in CPU system benches and FPGA loopback builds.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; must be even and ≥4.
- DATA_W, 16: CPU data bus width; only bits [7:0] carry UART data.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- bus_data_in  in  DATA_W  CPU data bus value during writes.
- bus_data_out  out  DATA_W  read data: {zeros, RBR[7:0]}.
- bus_data_oe  out  1  high while the responder drives the bus.
- rdn  in  1  read strobe, active-low.
- wrn  in  1  write strobe, active-low.
- tbre  out  1  transmit holding register (THR) empty.
- tsre  out  1  transmit shift register empty (line idle).
- data_ready  out  1  receive buffer (RBR) holds an unread byte.
- rx_overrun  out  1  sticky flag: a byte was overwritten before it was read.
- txd  out  1  serial transmit line, idle high.
- rxd  in  1  serial receive line, asynchronous.

Behaviour:
- Reset (sync): txd=1, tbre=1, tsre=1, data_ready=0, rx_overrun=0, bus_data_out=0, bus_data_oe=0. Both FSMs return to IDLE; THR/RBR contents are don't-care. Reset mid-frame aborts the frame; txd=1 on the cycle after reset is sampled.
- Strobe sampling: rdn and wrn are registered each clk into rdn_q/wrn_q. A rising edge is the cycle where strobe=1 and strobe_q=0.
- Write commit (wrn rising edge):
  - If tbre=1: THR<=bus_data_in[7:0] and tbre<=0 at that edge.
  - If tbre=0: the write is dropped and THR is unchanged.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE with tbre=0: load shifter from THR, tbre<=1, tsre<=0, txd<=0, go to START. This is one cycle after the commit edge.
  - START and each of 8 DATA bits (LSB first) and STOP (txd=1) each last exactly CLKS_PER_BIT cycles.
  - End of STOP: if tbre=0, load the next byte immediately (back-to-back, no idle bit, tsre stays 0). Otherwise tsre<=1 and go to IDLE.
  - txd is registered. Frame = 10*CLKS_PER_BIT cycles from txd falling to the next possible start.
- Read:
  - bus_data_oe = ~rdn, combinational, so data is valid within the same cycle.
  - bus_data_out = {(DATA_W-8) zeros, RBR}, held constant while rdn=0.
  - rdn rising edge clears data_ready and rx_overrun.
- Receiver:
  - rxd passes through a 2-flop synchronizer; all RX logic uses the synchronized value.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a synchronized 1->0 transition enters START.
  - START: sample at CLKS_PER_BIT/2. If the sample is 1 (glitch), return to IDLE with no side effect; otherwise go to DATA.
  - DATA: sample 8 bits, each one full CLKS_PER_BIT after the previous sample, LSB first.
  - STOP: sample once.
    - Sample 1: RBR<=byte and data_ready<=1. If data_ready was already 1 and is not being cleared this cycle, also rx_overrun<=1.
    - Sample 0 (framing error): discard the byte; data_ready and RBR are unchanged.
    - Either way, return to IDLE immediately and await the next falling edge.
- Simultaneous events:
  - RX commit in the same cycle as an rdn rising edge: the new byte wins, data_ready=1, rx_overrun=0.
  - rdn low during an RX commit: bus_data_out switches to the new RBR on the next cycle.
  - wrn rising edge in the same cycle the TX FSM empties THR (tbre=0): the write is dropped, because the tbre value sampled at the edge governs.
  - rdn and wrn both low: both actions are performed independently.
- Widths: bit counters 4 bits; baud counter $clog2(CLKS_PER_BIT) bits, wrapping at CLKS_PER_BIT-1.

Decomposition:
- Package uart_pkg: tx/rx state encodings (IDLE=0, START=1, DATA=2, STOP=3), UART_DATA_BITS=8, UART_FRAME_BITS=10, and the DATA_W default (16, the codebase DATA_BUS width).
- Sub-module uart_rx_core holds the synchronizer, RX FSM and baud counter. It outputs a one-cycle rx_valid, rx_byte and rx_frame_err.
- TX path, bus logic and status flags stay in the top level.

Test Plan:
- Reset then idle 100 cycles -> txd=1, tbre=1, tsre=1, data_ready=0, bus_data_oe=0 throughout.
- wrn pulse with bus_data_in=16'h0155 (CLKS_PER_BIT=16) -> tbre=0 at the commit edge, then tbre=1 and tsre=0 with txd falling 1 cycle later. txd sequence 0,1,0,1,0,1,0,1,0,1, 16 cycles each. tsre=1 exactly 160 cycles after txd falls.
- Two writes (0x41, then 0x42 while shifting) -> back-to-back frames with no idle gap. A third write while tbre=0 is dropped; only 0x41 and 0x42 appear on txd.
- Drive rxd frame for 0xA5 with a good stop bit -> data_ready=1 after stop sample. rdn low -> bus_data_oe=1, bus_data_out=16'h00A5 same cycle. rdn high -> data_ready=0.
- Two rx frames 0x11 then 0x22, no read -> RBR=0x22, rx_overrun=1. Frame with stop bit 0 -> data_ready unchanged. 4-cycle low glitch on rxd -> no reception.
- Assert rst mid-TX frame (bit 3) and mid-RX frame -> next cycle txd=1, tsre=1, tbre=1, data_ready=0. The next write transmits a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART responder: state encodings for the TX and
// RX framers, frame geometry and the default CPU data bus width.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int DATA_BUS_W      = 16;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer on rxd, start-bit qualification,
// mid-bit sampling of 8 data bits (LSB first) and a stop-bit check.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rxd_i           asynchronous serial input, idle high
//   rx_valid_o      one-cycle pulse when a frame has completed
//   rx_byte_o       received byte, valid with rx_valid_o
//   rx_frame_err_o  qualifies rx_valid_o: stop bit was sampled low
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [3:0]    BIT_LAST  = 4'(UART_DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          fall;
  logic          baud_last;

  // Synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall      = rx_prev_q & ~rx_sync_q;
  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fall) state_d = ST_START;
      // A start bit that is high again at mid-bit was a glitch
      ST_START: if (baud_q == BAUD_HALF) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
      ST_DATA:  if (baud_last && bit_q == BIT_LAST) state_d = ST_STOP;
      ST_STOP:  if (baud_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    baud_d  = baud_last ? '0 : baud_q + BAUD_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
      end
      ST_START: begin
        bit_d = '0;
        // Restart the count at mid-bit so later samples land mid-bit too
        if (baud_q == BAUD_HALF) baud_d = '0;
      end
      ST_DATA: begin
        if (baud_last) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 4'd1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          valid_d = 1'b1;
          ferr_d  = ~rx_sync_q;
        end
      end
      default: baud_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q  <= '0;
      bit_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_valid_o     = valid_q;
  assign rx_byte_o      = shift_q;
  assign rx_frame_err_o = ferr_q;

endmodule

// File: rtl/uart_responder.sv
// Device-side model of the board UART as seen from the CPU port. Writes
// (wrn rising edge) load the transmit holding register, which is serialized
// on txd as 8N1; bytes received on rxd land in the receive buffer, readable
// on the bus while rdn is low.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   bus_data_in      CPU write data, bits [7:0] used
//   bus_data_out     {zeros, RBR}
//   bus_data_oe      high while rdn is low
//   rdn, wrn         active-low read / write strobes
//   tbre, tsre       THR empty / transmit shifter empty
//   data_ready       RBR holds an unread byte
//   rx_overrun       sticky: unread byte was overwritten
//   txd, rxd         serial lines, idle high
module uart_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = DATA_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_data_oe,
  input  logic              rdn,
  input  logic              wrn,
  output logic              tbre,
  output logic              tsre,
  output logic              data_ready,
  output logic              rx_overrun,
  output logic              txd,
  input  logic              rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [3:0]    BIT_LAST  = 4'(UART_DATA_BITS - 1);

  logic rdn_q, wrn_q;
  logic rd_rise, wr_rise;

  // Strobe history for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_q <= 1'b1;
      wrn_q <= 1'b1;
    end else begin
      rdn_q <= rdn;
      wrn_q <= wrn;
    end
  end

  assign rd_rise = rdn & ~rdn_q;
  assign wr_rise = wrn & ~wrn_q;

  // Upper bus bits carry no UART data
  logic unused_bus_hi;
  assign unused_bus_hi = ^bus_data_in[DATA_W-1:8];

  // ---------------- transmit path ----------------
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [7:0]    thr_q;
  logic          txd_q, txd_d;
  logic          tsre_q, tsre_d;
  logic          tbre_q;
  logic          tx_load;
  logic          tx_last;

  assign tx_last = (tx_baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) tx_state_q <= ST_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      ST_IDLE:  if (!tbre_q) tx_state_d = ST_START;
      ST_START: if (tx_last) tx_state_d = ST_DATA;
      ST_DATA:  if (tx_last && tx_bit_q == BIT_LAST) tx_state_d = ST_STOP;
      // A pending byte at the end of STOP starts the next frame with no gap
      ST_STOP:  if (tx_last) tx_state_d = tbre_q ? ST_IDLE : ST_START;
      default:  tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_load    = 1'b0;
    txd_d      = txd_q;
    tsre_d     = tsre_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_baud_d  = tx_last ? '0 : tx_baud_q + BAUD_ONE;
    case (tx_state_q)
      ST_IDLE: begin
        tx_baud_d = '0;
        tx_bit_d  = '0;
        tx_load   = ~tbre_q;
      end
      ST_START: begin
        if (tx_last) begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tx_last) begin
          if (tx_bit_q == BIT_LAST) begin
            txd_d = 1'b1;
          end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tx_last) begin
          if (!tbre_q) tx_load = 1'b1;
          else         tsre_d  = 1'b1;
        end
      end
      default: tx_baud_d = '0;
    endcase
    if (tx_load) begin
      txd_d      = 1'b0;
      tsre_d     = 1'b0;
      tx_shift_d = thr_q;
      tx_baud_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      txd_q     <= 1'b1;
      tsre_q    <= 1'b1;
      tbre_q    <= 1'b1;
    end else begin
      tx_baud_q <= tx_baud_d;
      tx_bit_q  <= tx_bit_d;
      txd_q     <= txd_d;
      tsre_q    <= tsre_d;
      // Commit and load are exclusive: commit needs tbre=1, load needs tbre=0
      if (wr_rise && tbre_q) tbre_q <= 1'b0;
      else if (tx_load)      tbre_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    if (wr_rise && tbre_q) thr_q <= bus_data_in[7:0];
  end

  // ---------------- receive path ----------------
  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] rx_byte;
  logic       rx_commit;
  logic [7:0] rbr_q;
  logic       dr_q, ovr_q;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk            (clk),
    .rst            (rst),
    .rxd_i          (rxd),
    .rx_valid_o     (rx_valid),
    .rx_byte_o      (rx_byte),
    .rx_frame_err_o (rx_frame_err)
  );

  assign rx_commit = rx_valid & ~rx_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rbr_q <= '0;
      dr_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else if (rx_commit) begin
      rbr_q <= rx_byte;
      dr_q  <= 1'b1;
      // A read completing in this cycle consumed the old byte, so no overrun
      ovr_q <= rd_rise ? 1'b0 : (ovr_q | dr_q);
    end else if (rd_rise) begin
      dr_q  <= 1'b0;
      ovr_q <= 1'b0;
    end
  end

  assign bus_data_out = {{(DATA_W-8){1'b0}}, rbr_q};
  assign bus_data_oe  = ~rdn;
  assign tbre         = tbre_q;
  assign tsre         = tsre_q;
  assign txd          = txd_q;
  assign data_ready   = dr_q;
  assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_responder.sv
module tb_uart_responder;

  localparam int C  = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] bus_data_in = '0;
  logic [DW-1:0] bus_data_out;
  logic          bus_data_oe;
  logic          rdn = 1'b1;
  logic          wrn = 1'b1;
  logic          tbre, tsre, data_ready, rx_overrun, txd;
  logic          rxd = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [8:0] tx_got[$];
  int         tx_start[$];
  logic [8:0] tx_exp[$];

  logic       m_dr, m_ovr;
  logic [7:0] m_rbr;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       rd;
    logic       dr;
    logic       ovr;
    logic [7:0] rbr;
  } rxvec_t;
  rxvec_t vt[7];

  uart_responder #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .rdn          (rdn),
    .wrn          (wrn),
    .tbre         (tbre),
    .tsre         (tsre),
    .data_ready   (data_ready),
    .rx_overrun   (rx_overrun),
    .txd          (txd),
    .rxd          (rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Line-level decoder for txd: frame start at a high-to-low transition,
  // then samples at the middle of each bit period.
  initial begin : tx_mon
    int         phase;
    logic       prev;
    logic [7:0] b;
    phase = -1;
    prev  = 1'b1;
    b     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = -1;
      end else if (phase < 0) begin
        if (prev && !txd) begin
          phase = 0;
          tx_start.push_back(cyc);
        end
      end else begin
        phase++;
        if (phase % C == C / 2) begin
          if (phase / C >= 1 && phase / C <= 8) b[phase / C - 1] = txd;
          if (phase / C == 9) begin
            tx_got.push_back({txd, b});
            phase = -1;
          end
        end
      end
      prev = txd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [DW-1:0] d);
    bus_data_in = d;
    wrn = 1'b0;
    @(negedge clk);
    wrn = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_cyc(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(C);
    end
    rxd = stop;
    wait_cyc(C);
    rxd = 1'b1;
    wait_cyc(C);
  endtask

  task automatic read_pulse(input logic [7:0] exp_rbr);
    rdn = 1'b0;
    #1;
    check("read_oe", bus_data_oe, 1'b1);
    check("read_data", bus_data_out, {8'h00, exp_rbr});
    @(negedge clk);
    rdn = 1'b1;
    @(negedge clk);
    check("read_clr", {data_ready, rx_overrun, bus_data_oe}, 3'b000);
  endtask

  task automatic compare_tx(input string name);
    check({name, "_count"}, tx_got.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      check($sformatf("%s_byte%0d", name, i), tx_got[i], tx_exp[i]);
    tx_got.delete();
    tx_exp.delete();
    tx_start.delete();
  endtask

  initial begin : stim
    logic [9:0] fr;
    logic [7:0] rb;
    logic       rs, rr;

    vt[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    vt[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
    vt[2] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22};
    vt[3] = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
    vt[4] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7E};
    vt[5] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7E};
    vt[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};

    // Reset and idle
    wait_cyc(3);
    check("rst_flags", {txd, tbre, tsre, data_ready, rx_overrun, bus_data_oe}, 6'b111000);
    check("rst_bus", bus_data_out, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle", {txd, tbre, tsre, data_ready, bus_data_oe}, 5'b11100);
    end

    // Single write, exact frame timing
    write_byte(16'h0155);
    @(negedge clk);
    check("commit_flags", {tbre, tsre, txd}, 3'b011);
    @(negedge clk);
    check("load_flags", {tbre, tsre, txd}, 3'b100);
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10 * C; i++) begin
      if (txd !== fr[i / C] || tsre !== 1'b0)
        check($sformatf("frame55_cyc%0d", i), {tsre, txd}, {1'b0, fr[i / C]});
      else
        checks++;
      @(negedge clk);
    end
    check("tsre_after_frame", {tsre, txd, tbre}, 3'b111);
    tx_exp.push_back(9'h155);
    wait_cyc(5);
    compare_tx("single");

    // Back-to-back frames, third write dropped
    write_byte(16'h0041);
    wait_cyc(20);
    write_byte(16'h0042);
    wait_cyc(5);
    check("tbre_full", tbre, 1'b0);
    write_byte(16'h0043);
    wait_cyc(400);
    check("b2b_gap", (tx_start.size() >= 2) ? tx_start[1] - tx_start[0] : -1, 10 * C);
    check("b2b_idle", {tsre, tbre, txd}, 3'b111);
    tx_exp.push_back(9'h141);
    tx_exp.push_back(9'h142);
    compare_tx("b2b");

    // Random TX bytes, spaced beyond a frame so every write is accepted
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      write_byte({8'($urandom), rb});
      tx_exp.push_back({1'b1, rb});
      wait_cyc(170 + $urandom_range(0, 40));
    end
    compare_tx("rand_tx");

    // Table-driven RX frames
    for (int i = 0; i < 7; i++) begin
      send_rx(vt[i].b, vt[i].stop);
      check($sformatf("vec%0d_dr", i), data_ready, vt[i].dr);
      check($sformatf("vec%0d_ovr", i), rx_overrun, vt[i].ovr);
      check($sformatf("vec%0d_rbr", i), bus_data_out, {8'h00, vt[i].rbr});
      if (vt[i].rd) read_pulse(vt[i].rbr);
    end

    // Short low glitch must not start a reception
    rxd = 1'b0;
    wait_cyc(4);
    rxd = 1'b1;
    wait_cyc(40);
    check("glitch_dr", data_ready, 1'b0);
    check("glitch_rbr", bus_data_out, 16'h0000);

    // rdn held low across a commit: bus follows the new byte
    rdn = 1'b0;
    send_rx(8'h5C, 1'b1);
    check("rdlow_oe", bus_data_oe, 1'b1);
    check("rdlow_data", bus_data_out, 16'h005C);
    rdn = 1'b1;
    wait_cyc(2);
    check("rdlow_clr", {data_ready, rx_overrun}, 2'b00);

    // Random RX against a status model
    m_dr = 1'b0; m_ovr = 1'b0; m_rbr = 8'h5C;
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rr = 1'($urandom);
      send_rx(rb, rs);
      if (rs) begin
        m_ovr = m_ovr | m_dr;
        m_dr  = 1'b1;
        m_rbr = rb;
      end
      check($sformatf("rrx%0d_status", i), {data_ready, rx_overrun}, {m_dr, m_ovr});
      check($sformatf("rrx%0d_rbr", i), bus_data_out, {8'h00, m_rbr});
      if (rr) begin
        read_pulse(m_rbr);
        m_dr = 1'b0;
        m_ovr = 1'b0;
      end
    end

    // Reset mid-TX (bit 3) and mid-RX
    send_rx(8'h3C, 1'b1);
    check("pre_rst_dr", data_ready, 1'b1);
    write_byte(16'h005A);
    wait_cyc(2);
    rxd = 1'b0;
    wait_cyc(70);
    check("pre_rst_txd", {tsre, txd}, 2'b01);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    check("mid_rst_flags", {txd, tsre, tbre, data_ready, rx_overrun}, 5'b11100);
    rst = 1'b0;
    wait_cyc(250);
    tx_got.delete();
    tx_start.delete();
    check("post_rst_quiet", {txd, tsre, tbre, data_ready}, 4'b1110);
    write_byte(16'h00C3);
    tx_exp.push_back(9'h1C3);
    wait_cyc(200);
    compare_tx("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
